ssd_scan_driver: RTL and testbench

//  Time-multiplexed seven-segment display driver for the stopwatch display path.
//  - Consumes the divided refresh clock level and steps through the digits on each refresh rising edge.
//  - Drives active-low anodes, segments and decimal point from a per-frame BCD snapshot.
//  - Sits between the stopwatch BCD counters and the board SSD pins.

---
 rtl/ssd_scan_driver.sv | 141 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver with per-frame BCD snapshot and anode dead time.
// Define SSD_LZ_BLANK_EN to build leading-zero blanking on the snapshot data.
module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int GHOST_CYCLES = 2
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Refresh_Clk,
    input  logic [4*NUM_DIGITS-1:0] Digits,
    input  logic [NUM_DIGITS-1:0]   Dp_Mask,
    output logic [NUM_DIGITS-1:0]   An,
    output logic [6:0]              Seg,
    output logic                    Dp,
    output logic                    Frame_Done
);

    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GW    = (GHOST_CYCLES > 0) ? $clog2(GHOST_CYCLES + 1) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    logic                    refresh_q;
    logic                    active_q, active_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [GW-1:0]           ghost_q, ghost_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_q, frame_d;

    logic       tick;
    logic [3:0] cur_digit;
    logic       cur_dp;
    logic       cur_blank;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign tick = Refresh_Clk & ~refresh_q;

    always_comb begin
        sel_d    = sel_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        frame_d  = 1'b0;
        active_d = active_q | tick;
        ghost_d  = (ghost_q != '0) ? ghost_q - GW'(1) : ghost_q;
        if (tick) begin
            ghost_d = GW'(GHOST_CYCLES);
            if (sel_q == LAST_SEL) begin
                sel_d    = '0;
                shadow_d = Digits;
                mask_d   = Dp_Mask;
                frame_d  = 1'b1;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    // Outputs are computed from next-state values so they land one cycle after the tick.
    always_comb begin
        logic zero_run;
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        an_d      = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (shadow_d[4*k +: 4] == 4'd0) & ~mask_d[k];
            if (SEL_W'(k) == sel_d) begin
                cur_digit = shadow_d[4*k +: 4];
                cur_dp    = mask_d[k];
                cur_blank = zero_run & (k != 0);
                an_d[k]   = 1'b0;
            end
        end
        seg_d = bcd_to_seg(cur_digit);
        dp_d  = ~cur_dp;
`ifdef SSD_LZ_BLANK_EN
        if (cur_blank) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
`endif
        if (!active_d) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
        if (!active_d || ghost_d != '0) an_d = '1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            refresh_q <= 1'b0;
            active_q  <= 1'b0;
            sel_q     <= LAST_SEL;
            ghost_q   <= '0;
            shadow_q  <= '0;
            mask_q    <= '0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            refresh_q <= Refresh_Clk;
            active_q  <= active_d;
            sel_q     <= sel_d;
            ghost_q   <= ghost_d;
            shadow_q  <= shadow_d;
            mask_q    <= mask_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign An         = an_q;
    assign Seg        = seg_q;
    assign Dp         = dp_q;
    assign Frame_Done = frame_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver at NUM_DIGITS=4, GHOST_CYCLES=2.
module tb_ssd_scan_driver;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Refresh_Clk;
    logic [15:0] Digits;
    logic [3:0]  Dp_Mask;
    logic [3:0]  An;
    logic [6:0]  Seg;
    logic        Dp;
    logic        Frame_Done;

    int checks = 0;
    int errors = 0;

    ssd_scan_driver #(.NUM_DIGITS(4), .GHOST_CYCLES(2)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Refresh_Clk(Refresh_Clk),
        .Digits     (Digits),
        .Dp_Mask    (Dp_Mask),
        .An         (An),
        .Seg        (Seg),
        .Dp         (Dp),
        .Frame_Done (Frame_Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One refresh edge, then the dead time, then the lit digit.
    task automatic scan(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                        input logic exp_dp, input logic exp_fd);
        Refresh_Clk = 1'b1;
        step();
        Refresh_Clk = 1'b0;
        check({tag, ".seg"}, 32'(Seg), 32'(exp_seg));
        check({tag, ".dp"}, 32'(Dp), 32'(exp_dp));
        check({tag, ".fd"}, 32'(Frame_Done), 32'(exp_fd));
        check({tag, ".dead1"}, 32'(An), 32'hF);
        step();
        check({tag, ".dead2"}, 32'(An), 32'hF);
        check({tag, ".fd_off"}, 32'(Frame_Done), 32'h0);
        step();
        check({tag, ".an"}, 32'(An), 32'(exp_an));
        check({tag, ".seg_hold"}, 32'(Seg), 32'(exp_seg));
        step();
        check({tag, ".an_hold"}, 32'(An), 32'(exp_an));
    endtask

    initial begin
        Rst_n       = 1'b0;
        Refresh_Clk = 1'b0;
        Digits      = 16'h1234;
        Dp_Mask     = 4'b0000;
        step();
        step();
        check("rst.an", 32'(An), 32'hF);
        check("rst.seg", 32'(Seg), 32'h7F);
        check("rst.dp", 32'(Dp), 32'h1);
        check("rst.fd", 32'(Frame_Done), 32'h0);
        Rst_n = 1'b1;
        step();
        step();

        scan("t1.d0", 4'b1110, 7'h19, 1'b1, 1'b1);
        scan("t2.d1", 4'b1101, 7'h30, 1'b1, 1'b0);
        scan("t2.d2", 4'b1011, 7'h24, 1'b1, 1'b0);
        scan("t2.d3", 4'b0111, 7'h79, 1'b1, 1'b0);
        scan("t2.d0", 4'b1110, 7'h19, 1'b1, 1'b1);

        scan("t3.d1", 4'b1101, 7'h30, 1'b1, 1'b0);
        scan("t3.d2", 4'b1011, 7'h24, 1'b1, 1'b0);
        Digits = 16'h5678;
        step();
        check("t3.nochange", 32'(Seg), 32'h24);
        scan("t3.d3", 4'b0111, 7'h79, 1'b1, 1'b0);
        scan("t3.d0", 4'b1110, 7'h00, 1'b1, 1'b1);

        Digits  = 16'h0059;
        Dp_Mask = 4'b0100;
        scan("t4.old1", 4'b1101, 7'h78, 1'b1, 1'b0);
        scan("t4.old2", 4'b1011, 7'h02, 1'b1, 1'b0);
        scan("t4.old3", 4'b0111, 7'h12, 1'b1, 1'b0);
        scan("t4.d0", 4'b1110, 7'h10, 1'b1, 1'b1);
        scan("t4.d1", 4'b1101, 7'h12, 1'b1, 1'b0);
        scan("t4.d2", 4'b1011, 7'h40, 1'b0, 1'b0);
`ifdef SSD_LZ_BLANK_EN
        scan("t4.d3", 4'b0111, 7'h7F, 1'b1, 1'b0);
`else
        scan("t4.d3", 4'b0111, 7'h40, 1'b1, 1'b0);
`endif

        Digits = 16'h12B4;
        scan("t5.d0", 4'b1110, 7'h19, 1'b1, 1'b1);
        scan("t5.blank", 4'b1101, 7'h7F, 1'b1, 1'b0);

        // Two refresh edges one cycle apart.
        Refresh_Clk = 1'b1;
        step();
        Refresh_Clk = 1'b0;
        check("t5.bb.seg1", 32'(Seg), 32'h24);
        check("t5.bb.dp1", 32'(Dp), 32'h0);
        check("t5.bb.an1", 32'(An), 32'hF);
        step();
        Refresh_Clk = 1'b1;
        check("t5.bb.an2", 32'(An), 32'hF);
        step();
        Refresh_Clk = 1'b0;
        check("t5.bb.seg2", 32'(Seg), 32'h79);
        check("t5.bb.dp2", 32'(Dp), 32'h1);
        check("t5.bb.an3", 32'(An), 32'hF);
        step();
        check("t5.bb.an4", 32'(An), 32'hF);
        step();
        check("t5.bb.an5", 32'(An), 32'b0111);
        step();

        scan("t6.d0", 4'b1110, 7'h19, 1'b1, 1'b1);
        scan("t6.d1", 4'b1101, 7'h7F, 1'b1, 1'b0);
        scan("t6.d2", 4'b1011, 7'h24, 1'b0, 1'b0);
        #2;
        Rst_n = 1'b0;
        #1;
        check("t6.async.an", 32'(An), 32'hF);
        check("t6.async.seg", 32'(Seg), 32'h7F);
        check("t6.async.dp", 32'(Dp), 32'h1);
        check("t6.async.fd", 32'(Frame_Done), 32'h0);
        step();
        Digits  = 16'h1234;
        Dp_Mask = 4'b0000;
        Rst_n   = 1'b1;
        step();
        scan("t6.restart", 4'b1110, 7'h19, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
